uart_rx_fsmd: RTL

- Oversampling UART receiver; the downstream peer of the UART transmitter.
- Consumes the serial line (transmitter Tx_s or an external pin), recovers start/data/parity/stop framing at no_of_clks samples per bit, and presents a parallel word with a one-cycle valid strobe and error flags.
- Frame format and parameter set match the transmitter, so a Tx/Rx pair can be instantiated back to back.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx_fsmd.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the parity helper.
// Both the transmitter and the receiver use this parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_t;

    // Returns the parity bit for the given data. Unused upper bits must be zero.
    function automatic logic parity_bit(input logic [7:0] data, input logic even);
        return even ? (^data) : ~(^data);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line.
// Both flops reset to the idle level of 1.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_fsmd.sv
// Oversampling UART receiver: start/data/parity/stop recovery at no_of_clks
// clocks per bit, with a one-cycle valid strobe and parity/framing flags.
module uart_rx_fsmd
    import uart_pkg::*;
#(
    parameter int parity_on           = 1,
    parameter int data_size           = 8,
    parameter int sampling_cntr_width = 4,
    parameter int even_parity         = 1,
    parameter int no_of_clks          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx_s,
    output logic [data_size-1:0] Rx_output,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [sampling_cntr_width-1:0] SCNT_HALF = sampling_cntr_width'(no_of_clks/2 - 1);
    localparam logic [sampling_cntr_width-1:0] SCNT_LAST = sampling_cntr_width'(no_of_clks - 1);
    localparam logic [2:0]                     BCNT_LAST = 3'(data_size - 1);

    logic                           rx_sync;
    uart_state_t                    state_q;
    logic [sampling_cntr_width-1:0] scnt_q;
    logic [2:0]                     bcnt_q;
    logic [data_size-1:0]           shift_q;
    logic                           perr_q;
    logic [data_size-1:0]           rx_output_q;
    logic                           data_valid_q;
    logic                           parity_err_q;
    logic                           frame_err_q;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst),
        .async_i(Rx_s),
        .sync_o (rx_sync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            scnt_q       <= '0;
            bcnt_q       <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            rx_output_q  <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_sync) begin
                        state_q <= START;
                        scnt_q  <= '0;
                    end
                end
                // Half a bit in: confirm the start bit, or drop it as a glitch.
                START: begin
                    if (scnt_q == SCNT_HALF) begin
                        scnt_q <= '0;
                        if (rx_sync) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            bcnt_q  <= '0;
                            perr_q  <= 1'b0;
                        end
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_q  <= '0;
                        shift_q <= {rx_sync, shift_q[data_size-1:1]};
                        bcnt_q  <= bcnt_q + 1'b1;
                        if (bcnt_q == BCNT_LAST)
                            state_q <= (parity_on != 0) ? PARITY : STOP;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_q  <= '0;
                        perr_q  <= parity_bit(8'(shift_q), even_parity != 0) != rx_sync;
                        state_q <= STOP;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                // Leaving at mid-stop lets a back-to-back start edge be caught.
                STOP: begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_q       <= '0;
                        rx_output_q  <= shift_q;
                        parity_err_q <= (parity_on != 0) ? perr_q : 1'b0;
                        frame_err_q  <= ~rx_sync;
                        data_valid_q <= 1'b1;
                        state_q      <= rx_sync ? IDLE : WAIT_IDLE;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_sync)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Rx_output  = rx_output_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule
